// File: rtl/ext_share_arbiter.sv
// ext_share_arbiter: round-robin share of one 16->32 immediate extend unit among NUM_REQ requesters
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : per-requester request valid
//   req_ready    : per-requester accept (one-hot or zero, combinational)
//   req_imm16    : immediates, requester i on bits [16i+15:16i]
//   req_extop    : 0 = zero extend, 1 = sign extend
//   req_shift2   : branch-offset form (shift left 2), only with EXT_SHIFT2_EN defined
//   resp_valid   : output register holds a result
//   resp_ready   : consumer accepts the result
//   resp_data    : extended immediate
//   resp_id      : requester that produced resp_data
//   busy         : same as resp_valid
module ext_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_imm16,
    input  logic [NUM_REQ-1:0]     req_extop,
`ifdef EXT_SHIFT2_EN
    input  logic [NUM_REQ-1:0]     req_shift2,
`endif
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [31:0]            resp_data,
    output logic [ID_W-1:0]        resp_id,
    output logic                   busy
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state_q, state_d;
    logic [ID_W-1:0] last_q, gnt_idx, cand;
    logic [NUM_REQ-1:0] sel;
    logic gnt_any, slot_free, grant, ext_op;
    logic [15:0] imm;
    logic [31:0] ext_val, new_data;
    // Scan last+1, last+2, ... and keep the first valid requester found.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (!gnt_any && |(req_valid & (NUM_REQ'(1) << cand))) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end
    assign slot_free = (state_q == EMPTY) || resp_ready;
    assign grant     = slot_free && gnt_any;
    assign sel       = NUM_REQ'(1) << gnt_idx;
    assign req_ready = grant ? sel : '0;
    assign imm       = 16'(req_imm16 >> {gnt_idx, 4'b0000});
    assign ext_op    = |(req_extop & sel);
    // An unknown extend mode smears the immediate's sign bit across the whole word.
    always_comb begin
        case (ext_op)
            1'b0:    ext_val = {16'h0000, imm};
            1'b1:    ext_val = {{16{imm[15]}}, imm};
            default: ext_val = {32{imm[15]}};
        endcase
    end
`ifdef EXT_SHIFT2_EN
    assign new_data = |(req_shift2 & sel) ? {ext_val[29:0], 2'b00} : ext_val;
`else
    assign new_data = ext_val;
`endif
    // A grant always fills the slot; a free slot without a grant empties it.
    always_comb begin
        state_d = state_q;
        state_d = grant ? FULL : (slot_free ? EMPTY : state_q);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data <= '0;
            resp_id   <= '0;
            last_q    <= ID_W'(NUM_REQ - 1);
        end else if (grant) begin
            resp_data <= new_data;
            resp_id   <= gnt_idx;
            last_q    <= gnt_idx;
        end
    end
    assign resp_valid = (state_q == FULL);
    assign busy       = resp_valid;
endmodule

// File: tb/tb_ext_share_arbiter.sv
// tb_ext_share_arbiter: directed and randomized checks of ext_share_arbiter against a reference model
module tb_ext_share_arbiter;
    localparam int N  = 2;
    localparam int IW = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req_valid = '0, req_ready, req_extop = '0;
    logic [16*N-1:0] req_imm16 = '0;
`ifdef EXT_SHIFT2_EN
    logic [N-1:0] req_shift2 = '0;
`endif
    logic resp_valid, resp_ready = 1'b0, busy;
    logic [31:0] resp_data;
    logic [IW-1:0] resp_id;
    int checks = 0, failures = 0;
    bit mv;
    logic [31:0] md;
    int mid, mlast;
    logic [N-1:0] rdy_obs;

    ext_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_imm16(req_imm16), .req_extop(req_extop),
`ifdef EXT_SHIFT2_EN
        .req_shift2(req_shift2),
`endif
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input bit eo, input bit s2);
        longint v = longint'(imm);
        if (eo && imm >= 16'h8000) v = v - 65536;
`ifdef EXT_SHIFT2_EN
        if (s2) v = v * 4;
`else
        if (s2) v = v;
`endif
        return 32'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mv = 0; md = '0; mid = 0; mlast = N - 1;
    endtask

    task automatic check_outs();
        chk("resp_valid", 32'(resp_valid), 32'(mv));
        chk("busy", 32'(busy), 32'(mv));
        chk("resp_data", resp_data, md);
        chk("resp_id", 32'(resp_id), 32'(mid));
    endtask

    task automatic step(input logic [N-1:0] v, input logic [16*N-1:0] imm, input logic [N-1:0] eo,
                        input logic [N-1:0] s2, input logic rr);
        int w;
        bit free;
        @(negedge clk);
        req_valid = v; req_imm16 = imm; req_extop = eo; resp_ready = rr;
`ifdef EXT_SHIFT2_EN
        req_shift2 = s2;
`endif
        #1;
        free = !mv || rr;
        w = -1;
        if (free) for (int k = 1; k <= N; k++) begin
            int i = (mlast + k) % N;
            if (w < 0 && v[i]) w = i;
        end
        rdy_obs = req_ready;
        chk("req_ready", 32'(req_ready), w >= 0 ? 32'(1 << w) : 32'd0);
        @(posedge clk);
        #1;
        if (w >= 0) begin
            md = ref_ext(imm[16*w +: 16], eo[w], s2[w]); mid = w; mv = 1; mlast = w;
        end else if (free) mv = 0;
        check_outs();
    endtask

    initial begin
        logic [N-1:0] cv, ce, cs;
        logic [16*N-1:0] ci;
        model_reset();
        #3;
        check_outs();
        chk("reset_ready", 32'(req_ready), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        // sign extend of a negative immediate from requester 0
        step(2'b01, {16'h0000, 16'h8001}, 2'b01, 2'b00, 1'b1);
        chk("t1_ready", 32'(rdy_obs), 32'h1);
        chk("t1_data", resp_data, 32'hFFFF8001);
        chk("t1_id", 32'(resp_id), 32'd0);
        // zero extend from requester 1
        step(2'b10, {16'h8001, 16'h0000}, 2'b00, 2'b00, 1'b1);
        chk("t2_data", resp_data, 32'h00008001);
        chk("t2_id", 32'(resp_id), 32'd1);
        // both valid: rotation 0,1,0,1 at one result per cycle
        for (int j = 0; j < 4; j++) begin
            step(2'b11, {16'h1234, 16'h5678}, 2'b11, 2'b00, 1'b1);
            chk("rr_ready", 32'(rdy_obs), (j % 2) ? 32'h2 : 32'h1);
            chk("rr_id", 32'(resp_id), 32'(j % 2));
        end
        // consumer stalls: no grant, data held
        for (int j = 0; j < 3; j++) begin
            step(2'b01, {16'h0000, 16'hABCD}, 2'b01, 2'b00, 1'b0);
            chk("stall_ready", 32'(rdy_obs), 32'd0);
            chk("stall_data", resp_data, 32'h00001234);
        end
        // drain and refill in the same edge
        step(2'b01, {16'h0000, 16'hABCD}, 2'b01, 2'b00, 1'b1);
        chk("refill_ready", 32'(rdy_obs), 32'h1);
        chk("refill_data", resp_data, 32'hFFFFABCD);
        chk("refill_valid", 32'(resp_valid), 32'd1);
        // asynchronous reset while full
        @(negedge clk);
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 32'(resp_valid), 32'd0);
        check_outs();
        @(negedge clk) rst_n = 1'b1;
        step(2'b11, {16'h0002, 16'h0001}, 2'b00, 2'b00, 1'b1);
        chk("arst_ptr", 32'(rdy_obs), 32'h1);
`ifdef EXT_SHIFT2_EN
        step(2'b01, {16'h0000, 16'hFFFF}, 2'b01, 2'b01, 1'b1);
        chk("s2_neg", resp_data, 32'hFFFFFFFC);
        step(2'b01, {16'h0000, 16'h4000}, 2'b00, 2'b01, 1'b1);
        chk("s2_pos", resp_data, 32'h00010000);
`endif
        // randomized traffic; a pending request is held until accepted
        cv = '0; ce = '0; cs = '0; ci = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!cv[i] || rdy_obs[i]) begin
                    cv[i] = 1'($urandom_range(0, 1));
                    ce[i] = 1'($urandom_range(0, 1));
                    cs[i] = 1'($urandom_range(0, 1));
                    ci[16*i +: 16] = 16'($urandom);
                end
            end
            step(cv, ci, ce, cs, 1'($urandom_range(0, 3) != 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
